dm_sba_responder: RTL and testbench

// Responder (bus slave) end of the debug-module system-bus req/gnt/r_valid protocol.

---
 rtl/dm_sba_responder.sv | 162 ++++++++++++++++
 tb/tb_dm_sba_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_responder.sv
// Debug-module SBA responder: req/gnt/r_valid bus slave in front of a small scratch memory,
// with a configurable grant stall and response latency.
module dm_sba_responder #(
  parameter int unsigned         BusWidth   = 32,
  parameter int unsigned         Depth      = 16,
  parameter logic [BusWidth-1:0] BaseAddr   = '0,
  parameter int unsigned         GntDelay   = 0,
  parameter int unsigned         RspLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_req_i,
  input  logic [BusWidth-1:0]   slave_add_i,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  output logic                  slave_gnt_o,
  output logic                  slave_r_valid_o,
  output logic                  slave_r_err_o,
  output logic                  slave_r_other_err_o,
  output logic [BusWidth-1:0]   slave_r_rdata_o,
  output logic                  busy_o
);

  localparam int unsigned BeW      = BusWidth / 8;
  localparam int unsigned AddrLsb  = $clog2(BeW);
  localparam int unsigned IdxW     = $clog2(Depth);
  localparam int unsigned MemBytes = Depth * BeW;
  localparam int unsigned CntW     = 4;

  localparam logic [CntW-1:0] GntLoad = CntW'((GntDelay == 0) ? 0 : GntDelay - 1);
  localparam logic [CntW-1:0] RspLoad = CntW'(RspLatency - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  // Legal byte enables: naturally aligned power-of-two runs; all-zero only for reads.
  function automatic logic be_legal(input logic [BeW-1:0] be, input logic we);
    logic           ok;
    logic [BeW-1:0] mask;
    ok = 1'b0;
    if (be == '0) begin
      ok = !we;
    end else begin
      for (int s = 1; s <= int'(BeW); s = s * 2) begin
        for (int k = 0; k < int'(BeW); k = k + s) begin
          mask = BeW'(((1 << s) - 1) << k);
          if (be == mask) ok = 1'b1;
        end
      end
    end
    return ok;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BusWidth-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_oerr_q, rsp_oerr_d;
  logic [BusWidth-1:0] mem_q [Depth];
  logic [BusWidth-1:0] mem_d [Depth];

  logic                gnt_c;
  logic                r_valid_c;
  logic [BusWidth-1:0] offset;
  logic                in_range;
  logic [IdxW-1:0]     word_idx;
  logic                be_ok;

  assign offset   = slave_add_i - BaseAddr;
  assign in_range = offset < BusWidth'(MemBytes);
  assign word_idx = offset[AddrLsb +: IdxW];
  assign be_ok    = be_legal(slave_be_i, slave_we_i);

  // Next-state, grant and access logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_oerr_d = rsp_oerr_q;
    mem_d      = mem_q;
    gnt_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (slave_req_i) begin
          if (GntDelay == 0) begin
            gnt_c   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = GntLoad;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!slave_req_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          gnt_c   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Access happens in the grant cycle; read data is frozen here.
    if (gnt_c) begin
      cnt_d      = RspLoad;
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      rsp_oerr_d = 1'b0;
      if (!be_ok) begin
        rsp_oerr_d = 1'b1;
      end else if (!in_range) begin
        rsp_err_d = 1'b1;
      end else if (slave_we_i) begin
        for (int b = 0; b < int'(BeW); b++) begin
          if (slave_be_i[b]) mem_d[word_idx][8*b +: 8] = slave_wdata_i[8*b +: 8];
        end
      end else begin
        rsp_data_d = mem_q[word_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_oerr_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_oerr_q <= rsp_oerr_d;
      mem_q      <= mem_d;
    end
  end

  // Outputs are forced low while reset is asserted, so a reset in Resp drops the response.
  assign r_valid_c           = rst_ni && (state_q == RESP) && (cnt_q == '0);
  assign slave_gnt_o         = rst_ni && gnt_c;
  assign slave_r_valid_o     = r_valid_c;
  assign slave_r_err_o       = r_valid_c && rsp_err_q;
  assign slave_r_other_err_o = r_valid_c && rsp_oerr_q;
  assign slave_r_rdata_o     = r_valid_c ? rsp_data_q : '0;
  assign busy_o              = rst_ni && (state_q != IDLE);

endmodule

// File: tb/tb_dm_sba_responder.sv
// Bench for dm_sba_responder: three instances with different stall/latency settings,
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_dm_sba_responder;

  localparam int NI   = 3;
  localparam int DEP  = 16;
  localparam int MEMB = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  function automatic int g_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 3 : 2;
  endfunction
  function automatic int l_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 2;
  endfunction

  logic        clk;
  logic        rst_n [NI];
  logic        req   [NI];
  logic [31:0] add   [NI];
  logic        we    [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  be    [NI];
  logic        gnt   [NI];
  logic        rv    [NI];
  logic        err   [NI];
  logic        oerr  [NI];
  logic [31:0] rdata [NI];
  logic        busy  [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dm_sba_responder #(
      .BusWidth  (32),
      .Depth     (16),
      .BaseAddr  (BASE),
      .GntDelay  ((gi == 0) ? 0 : (gi == 1) ? 3 : 2),
      .RspLatency((gi == 0) ? 1 : (gi == 1) ? 4 : 2)
    ) u_dut (
      .clk_i              (clk),
      .rst_ni             (rst_n[gi]),
      .slave_req_i        (req[gi]),
      .slave_add_i        (add[gi]),
      .slave_we_i         (we[gi]),
      .slave_wdata_i      (wdata[gi]),
      .slave_be_i         (be[gi]),
      .slave_gnt_o        (gnt[gi]),
      .slave_r_valid_o    (rv[gi]),
      .slave_r_err_o      (err[gi]),
      .slave_r_other_err_o(oerr[gi]),
      .slave_r_rdata_o    (rdata[gi]),
      .busy_o             (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [NI][DEP];
  int          wait_start [NI];
  int          grant_cyc  [NI];
  logic [31:0] h_rd   [NI];
  logic        h_err  [NI];
  logic        h_oerr [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      wait_start[i] = -1;
      grant_cyc[i]  = -1;
      h_rd[i] = '0; h_err[i] = 1'b0; h_oerr[i] = 1'b0;
      for (int w = 0; w < DEP; w++) m_mem[i][w] = '0;
    end
  end

  // Legal: empty on reads, else n in {1,2,4} contiguous set bits starting at a multiple of n.
  function automatic bit be_ok(input logic [3:0] b, input logic w);
    int n, lo;
    logic [3:0] run;
    if (b == 4'b0) return !w;
    n  = $countones(b);
    lo = 0;
    for (int k = 3; k >= 0; k--) if (b[k]) lo = k;
    run = 4'(((1 << n) - 1) << lo);
    return (n == 1 || n == 2 || n == 4) && (run == b) && (lo % n == 0);
  endfunction

  task automatic model_access(input int i);
    logic [31:0] off;
    int w;
    off = add[i] - BASE;
    h_err[i] = 1'b0; h_oerr[i] = 1'b0; h_rd[i] = '0;
    if (!be_ok(be[i], we[i])) begin
      h_oerr[i] = 1'b1;
    end else if (off >= 32'(MEMB)) begin
      h_err[i] = 1'b1;
    end else begin
      w = int'(off >> 2);
      if (we[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[i][b]) m_mem[i][w][8*b +: 8] = wdata[i][8*b +: 8];
        end
      end else begin
        h_rd[i] = m_mem[i][w];
      end
    end
  endtask

  task automatic model_check(input int i);
    logic e_gnt, e_rv, e_err, e_oerr, e_busy;
    logic [31:0] e_rd;
    string p;
    {e_gnt, e_rv, e_err, e_oerr, e_busy} = 5'b0;
    e_rd = '0;
    if (!rst_n[i]) begin
      wait_start[i] = -1;
      grant_cyc[i]  = -1;
      for (int w = 0; w < DEP; w++) m_mem[i][w] = '0;
    end else if (grant_cyc[i] >= 0) begin
      e_busy = 1'b1;
      if (cyc == grant_cyc[i] + l_of(i)) begin
        e_rv = 1'b1; e_err = h_err[i]; e_oerr = h_oerr[i]; e_rd = h_rd[i];
        grant_cyc[i] = -1;
      end
    end else begin
      if (wait_start[i] >= 0) begin
        e_busy = 1'b1;
        if (!req[i]) wait_start[i] = -1;
        else if (cyc - wait_start[i] == g_of(i)) e_gnt = 1'b1;
      end else if (req[i]) begin
        if (g_of(i) == 0) e_gnt = 1'b1;
        else wait_start[i] = cyc;
      end
      if (e_gnt) begin
        wait_start[i] = -1;
        grant_cyc[i]  = cyc;
        model_access(i);
      end
    end
    p = $sformatf("inst%0d cyc%0d", i, cyc);
    chk({p, " gnt"},       32'(gnt[i]),  32'(e_gnt));
    chk({p, " r_valid"},   32'(rv[i]),   32'(e_rv));
    chk({p, " r_err"},     32'(err[i]),  32'(e_err));
    chk({p, " other_err"}, 32'(oerr[i]), 32'(e_oerr));
    chk({p, " rdata"},     rdata[i],     e_rd);
    chk({p, " busy"},      32'(busy[i]), 32'(e_busy));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) model_check(i);
    cyc++;
  end

  // ---------------- directed stimulus helpers ----------------
  // Called #1 after a posedge; returns #1 after the posedge that ends the r_valid cycle.
  task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic e,
                     output logic oe, output int gl, output int rl, output int bc);
    req[i] = 1'b1; we[i] = w; add[i] = a; wdata[i] = d; be[i] = b;
    gl = -1; rl = -1; bc = 0; rd = '0; e = 1'b0; oe = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (busy[i]) bc++;
      if (gl < 0 && gnt[i]) gl = k;
      else if (gl >= 0 && rv[i]) begin
        rl = k - gl; rd = rdata[i]; e = err[i]; oe = oerr[i];
      end
      @(posedge clk); #1;
      if (gl >= 0) req[i] = 1'b0;
      if (rl >= 0) break;
    end
    req[i] = 1'b0;
    chk($sformatf("inst%0d txn completes", i), 32'(rl >= 0), 32'd1);
  endtask

  task automatic rand_fields(input int i);
    we[i] = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) add[i] = BASE - 32'($urandom_range(1, 16));
    else                           add[i] = BASE + 32'($urandom_range(0, MEMB + 15));
    wdata[i] = $urandom;
    if ($urandom_range(0, 3) == 0) be[i] = 4'($urandom_range(0, 15));
    else begin
      case ($urandom_range(0, 6))
        0: be[i] = 4'b0001;
        1: be[i] = 4'b0010;
        2: be[i] = 4'b0100;
        3: be[i] = 4'b1000;
        4: be[i] = 4'b0011;
        5: be[i] = 4'b1100;
        default: be[i] = 4'b1111;
      endcase
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic e, oe;
    int gl, rl, bc, ng, nr;
    bit pend [NI];
    logic g_now [NI];

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; add[i] = BASE; we[i] = 1'b0;
      wdata[i] = '0; be[i] = '0; pend[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

    // Full-word write then read, zero stall.
    txn(0, 1'b1, BASE + 4, 32'hDEADBEEF, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t1 write gnt latency", 32'(gl), 32'd0);
    chk("t1 write rsp latency", 32'(rl), 32'd1);
    chk("t1 write busy cycles", 32'(bc), 32'd1);
    chk("t1 write rdata", rd, 32'h0);
    chk("t1 write errs", 32'({e, oe}), 32'd0);
    txn(0, 1'b0, BASE + 4, 32'h0, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t1 read rdata", rd, 32'hDEADBEEF);
    chk("t1 read errs", 32'({e, oe}), 32'd0);

    // Single-byte write into lane 2.
    txn(0, 1'b1, BASE + 6, 32'h00AA0000, 4'b0100, rd, e, oe, gl, rl, bc);
    txn(0, 1'b0, BASE + 4, 32'h0, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t2 byte merge", rd, 32'hDEAABEEF);

    // Stalled grant and long latency.
    txn(1, 1'b0, BASE + 4, 32'h0, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t3 gnt latency G3", 32'(gl), 32'd3);
    chk("t3 rsp latency L4", 32'(rl), 32'd4);
    chk("t3 busy cycles", 32'(bc), 32'd7);
    txn(2, 1'b0, BASE, 32'h0, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t3 gnt latency G2", 32'(gl), 32'd2);
    chk("t3 rsp latency L2", 32'(rl), 32'd2);
    chk("t3 busy cycles G2L2", 32'(bc), 32'd4);

    // Out of range.
    txn(0, 1'b0, BASE + 64, 32'h0, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t4 oor read err/other", 32'({e, oe}), 32'b10);
    chk("t4 oor read rdata", rd, 32'h0);
    txn(0, 1'b1, BASE + 64, 32'h12345678, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t4 oor write err/other", 32'({e, oe}), 32'b10);
    txn(0, 1'b0, BASE - 4, 32'h0, 4'b1111, rd, e, oe, gl, rl, bc);
    chk("t4 below-base err", 32'({e, oe}), 32'b10);

    // Illegal byte enables, including priority over out-of-range.
    txn(0, 1'b1, BASE + 4, 32'hFFFFFFFF, 4'b0110, rd, e, oe, gl, rl, bc);
    chk("t5 be0110 err/other", 32'({e, oe}), 32'b01);
    txn(0, 1'b1, BASE + 4, 32'hFFFFFFFF, 4'b0000, rd, e, oe, gl, rl, bc);
    chk("t5 be0000 write err/other", 32'({e, oe}), 32'b01);
    txn(0, 1'b0, BASE + 64, 32'h0, 4'b0110, rd, e, oe, gl, rl, bc);
    chk("t5 illegal be beats oor", 32'({e, oe}), 32'b01);
    txn(0, 1'b0, BASE + 5, 32'h0, 4'b0000, rd, e, oe, gl, rl, bc);
    chk("t5 be0000 read rdata", rd, 32'hDEAABEEF);
    chk("t5 be0000 read errs", 32'({e, oe}), 32'd0);
    for (int w = 0; w < DEP; w++) begin
      txn(0, 1'b0, BASE + 32'(4 * w), 32'h0, 4'b1111, rd, e, oe, gl, rl, bc);
      chk($sformatf("t4/t5 readback word%0d", w), rd, (w == 1) ? 32'hDEAABEEF : 32'h0);
    end

    // Request abandoned during stall.
    req[2] = 1'b1; we[2] = 1'b1; add[2] = BASE; wdata[2] = 32'hFFFFFFFF; be[2] = 4'b1111;
    ng = 0; nr = 0;
    @(negedge clk);
    if (gnt[2]) ng++;
    @(posedge clk); #1;
    req[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (gnt[2]) ng++;
      if (rv[2]) nr++;
    end
    chk("t6 abort gnt count", 32'(ng), 32'd0);
    chk("t6 abort r_valid count", 32'(nr), 32'd0);
    chk("t6 abort busy", 32'(busy[2]), 32'd0);
    @(posedge clk); #1;

    // Reset while a response is pending.
    req[1] = 1'b1; we[1] = 1'b0; add[1] = BASE; be[1] = 4'b1111;
    ng = 0;
    for (int k = 0; k < 16 && ng == 0; k++) begin
      @(negedge clk);
      if (gnt[1]) ng++;
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("t6 outputs in reset", 32'({gnt[1], rv[1], err[1], oerr[1], busy[1]}), 32'd0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    nr = 0;
    @(negedge clk);
    chk("t6 outputs after reset", 32'({gnt[1], rv[1], err[1], oerr[1], busy[1]}), 32'd0);
    chk("t6 rdata after reset", rdata[1], 32'h0);
    repeat (8) begin
      @(negedge clk);
      if (rv[1]) nr++;
    end
    chk("t6 dropped response", 32'(nr), 32'd0);
    @(posedge clk); #1;

    // Reset and request together: reset wins.
    rst_n[0] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    chk("t6 reset beats req gnt", 32'(gnt[0]), 32'd0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1; req[0] = 1'b0;

    // Randomized traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) g_now[i] = gnt[i];
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        rst_n[i] = ($urandom_range(0, 499) != 0);
        if (pend[i] && g_now[i]) pend[i] = 1'b0;
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          rand_fields(i);
        end
        req[i] = pend[i];
      end
    end
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; rst_n[i] = 1'b1;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
